// File: rtl/clock_pkg.sv
// clock_pkg: state encoding, blink mask bit positions and timeout width for the clock controller.
package clock_pkg;
    localparam int TIMEOUT_W = 6;
    localparam int BM_HOUR = 2;
    localparam int BM_MIN  = 1;
    localparam int BM_SEC  = 0;
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } state_e;
endpackage

// File: rtl/btn_edge.sv
// btn_edge: history flop on a debounced button level; rise_o is high while level=1 and history=0.
module btn_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic rise_o
);
    logic hist_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) hist_q <= 1'b0;
        else         hist_q <= btn_i;
    assign rise_o = btn_i & ~hist_q;
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: run/pause, HOUR->MIN->SEC set sequencing, blink mask and set-mode timeout.
// Optional inc auto-repeat in SET_HOUR/SET_MIN when CLOCK_SET_AUTO_REPEAT_EN is defined.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_S     = 30,
    parameter int REPEAT_DELAY  = 4,
    parameter int REPEAT_PERIOD = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_1hz_i,
    input  logic       tick_blink_i,
    input  logic       mode_btn_i,
    input  logic       inc_btn_i,
    input  logic       run_btn_i,
    output logic       sec_tick_o,
    output logic       min_inc_o,
    output logic       hour_inc_o,
    output logic       sec_clr_o,
    output logic       carry_inh_o,
    output logic [2:0] blink_mask_o,
    output logic [1:0] mode_o,
    output logic       running_o
);
    logic mode_rise, inc_rise, run_rise, rep, expire;
    state_e state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic phase_q, phase_d, running_q, running_d;
    logic sec_tick_q, hour_inc_q, min_inc_q, sec_clr_q, carry_inh_q;
    logic [2:0] blink_q, blink_d;

    btn_edge u_mode (.clk_i(clk_i), .rst_ni(rst_ni), .btn_i(mode_btn_i), .rise_o(mode_rise));
    btn_edge u_inc  (.clk_i(clk_i), .rst_ni(rst_ni), .btn_i(inc_btn_i),  .rise_o(inc_rise));
    btn_edge u_run  (.clk_i(clk_i), .rst_ni(rst_ni), .btn_i(run_btn_i),  .rise_o(run_rise));

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    logic [7:0] rcnt_q;
    logic hold_ok;
    assign hold_ok = inc_btn_i && !mode_rise && (state_q == ST_SET_HOUR || state_q == ST_SET_MIN);
    assign rep     = hold_ok && tick_blink_i && (rcnt_q == 8'(REPEAT_DELAY - 1));
    // after the first repeat, reload so the next one lands REPEAT_PERIOD strobes later
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni)           rcnt_q <= '0;
        else if (!hold_ok)     rcnt_q <= '0;
        else if (rep)          rcnt_q <= 8'(REPEAT_DELAY - REPEAT_PERIOD);
        else if (tick_blink_i) rcnt_q <= rcnt_q + 8'd1;
`else
    logic unused_repeat;
    assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rep = 1'b0;
`endif

    always_comb begin
        expire    = state_q != ST_RUN && tick_1hz_i && !inc_rise && !rep
                    && cnt_q == TIMEOUT_W'(TIMEOUT_S - 1);
        state_d   = expire ? ST_RUN : mode_rise ? state_e'(state_q + 2'd1) : state_q;
        cnt_d     = (state_d == ST_RUN || mode_rise || inc_rise || rep) ? '0
                    : cnt_q + TIMEOUT_W'(tick_1hz_i);
        running_d = running_q ^ (state_q == ST_RUN && run_rise);
        phase_d   = phase_q ^ tick_blink_i;
        blink_d   = '0;
        blink_d[BM_HOUR] = state_d == ST_SET_HOUR && phase_d;
        blink_d[BM_MIN]  = state_d == ST_SET_MIN  && phase_d;
        blink_d[BM_SEC]  = state_d == ST_SET_SEC  && phase_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            running_q   <= 1'b1;
            phase_q     <= 1'b0;
            sec_tick_q  <= 1'b0;
            hour_inc_q  <= 1'b0;
            min_inc_q   <= 1'b0;
            sec_clr_q   <= 1'b0;
            carry_inh_q <= 1'b0;
            blink_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            running_q   <= running_d;
            phase_q     <= phase_d;
            sec_tick_q  <= state_q == ST_RUN && tick_1hz_i && running_q;
            hour_inc_q  <= state_q == ST_SET_HOUR && (inc_rise || rep) && !mode_rise;
            min_inc_q   <= state_q == ST_SET_MIN && (inc_rise || rep) && !mode_rise;
            sec_clr_q   <= state_q == ST_SET_SEC && inc_rise && !mode_rise;
            carry_inh_q <= state_d != ST_RUN;
            blink_q     <= blink_d;
        end
    end

    assign sec_tick_o   = sec_tick_q;
    assign hour_inc_o   = hour_inc_q;
    assign min_inc_o    = min_inc_q;
    assign sec_clr_o    = sec_clr_q;
    assign carry_inh_o  = carry_inh_q;
    assign blink_mask_o = blink_q;
    assign mode_o       = state_q;
    assign running_o    = running_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed scenarios plus random stimulus against a behavioural model of the controller.
module tb_clock_set_ctrl;
    localparam int TO = 30;
    logic clk = 0, rst_n = 0, t1 = 0, tbk = 0, mb = 0, ib = 0, rb = 0;
    logic sec_tick, min_inc, hour_inc, sec_clr, carry_inh, running;
    logic [2:0] blink_mask;
    logic [1:0] mode;
    int n_chk = 0, n_fail = 0;
    int n_sec = 0, n_hinc = 0, n_minc = 0, n_clr = 0;
    int s0, s1;

    always #5 clk = ~clk;

    clock_set_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .tick_1hz_i(t1), .tick_blink_i(tbk),
        .mode_btn_i(mb), .inc_btn_i(ib), .run_btn_i(rb),
        .sec_tick_o(sec_tick), .min_inc_o(min_inc), .hour_inc_o(hour_inc),
        .sec_clr_o(sec_clr), .carry_inh_o(carry_inh), .blink_mask_o(blink_mask),
        .mode_o(mode), .running_o(running)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: mode as 0..3, idle = tick_1hz seen in SET since last mode/inc press
    int m_mode, m_idle;
    bit m_run, m_phase, pm, pi, pr, e_sec, e_hinc, e_minc, e_clr, mr, ir, rr, tmo;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_idle = 0; m_run = 1; m_phase = 0;
            pm = 0; pi = 0; pr = 0;
            e_sec = 0; e_hinc = 0; e_minc = 0; e_clr = 0;
        end else begin
            mr = mb && !pm; ir = ib && !pi; rr = rb && !pr;
            e_sec  = m_mode == 0 && t1 && m_run;
            e_hinc = m_mode == 1 && ir && !mr;
            e_minc = m_mode == 2 && ir && !mr;
            e_clr  = m_mode == 3 && ir && !mr;
            if (m_mode == 0 && rr) m_run = !m_run;
            tmo = m_mode != 0 && t1 && !ir && m_idle + 1 == TO;
            if (tmo) begin m_mode = 0; m_idle = 0; end
            else if (mr) begin m_mode = (m_mode + 1) % 4; m_idle = 0; end
            else if (ir || m_mode == 0) m_idle = 0;
            else if (t1) m_idle++;
            m_phase ^= tbk;
            pm = mb; pi = ib; pr = rb;
        end
    end

    always @(negedge clk) begin
        chk("sec_tick", int'(sec_tick), int'(e_sec));
        chk("hour_inc", int'(hour_inc), int'(e_hinc));
        chk("min_inc", int'(min_inc), int'(e_minc));
        chk("sec_clr", int'(sec_clr), int'(e_clr));
        chk("mode", int'(mode), m_mode);
        chk("running", int'(running), int'(m_run));
        chk("carry_inh", int'(carry_inh), int'(m_mode != 0));
        chk("blink_mask", int'(blink_mask), m_mode == 0 ? 0 : (int'(m_phase) << (3 - m_mode)));
        n_sec  += int'(sec_tick);
        n_hinc += int'(hour_inc);
        n_minc += int'(min_inc);
        n_clr  += int'(sec_clr);
    end

    task automatic cyc(input logic a, input logic b, input logic c, input logic d, input logic e);
        @(negedge clk); #1;
        t1 = a; tbk = b; mb = c; ib = d; rb = e;
    endtask

    initial begin
        repeat (3) cyc(0, 0, 0, 0, 0);
        rst_n = 1;
        cyc(0, 0, 0, 0, 0);
        chk("lit_reset_mode", int'(mode), 0);
        chk("lit_reset_running", int'(running), 1);
        chk("lit_reset_carry", int'(carry_inh), 0);
        s0 = n_sec;
        repeat (3) begin cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); end
        chk("lit_run_3_ticks", n_sec - s0, 3);
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0);
        s0 = n_sec;
        repeat (2) begin cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); end
        chk("lit_paused_ticks", n_sec - s0, 0);
        chk("lit_paused_running", int'(running), 0);
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0);
        s0 = n_sec;
        cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("lit_resumed_ticks", n_sec - s0, 1);
        s0 = n_hinc;
        cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0);
        repeat (2) begin cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0); end
        chk("lit_set_hour_mode", int'(mode), 1);
        chk("lit_hour_incs", n_hinc - s0, 2);
        chk("lit_set_carry", int'(carry_inh), 1);
        cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("lit_blink_on", int'(blink_mask), 4);
        cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("lit_blink_off", int'(blink_mask), 0);
        s0 = n_hinc; s1 = n_minc;
        cyc(0, 0, 1, 1, 0); cyc(0, 0, 0, 0, 0);
        chk("lit_mode_beats_inc", int'(mode), 2);
        chk("lit_no_hour_inc", n_hinc - s0, 0);
        chk("lit_no_min_inc", n_minc - s1, 0);
        repeat (29) begin cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); end
        chk("lit_29_ticks_still_min", int'(mode), 2);
        cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("lit_timeout_to_run", int'(mode), 0);
        repeat (3) begin cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0); end
        chk("lit_set_sec_mode", int'(mode), 3);
        s0 = n_clr;
        repeat (3) cyc(0, 0, 0, 1, 0);
        chk("lit_one_sec_clr", n_clr - s0, 1);
        rst_n = 0; #1;
        chk("lit_async_mode", int'(mode), 0);
        chk("lit_async_carry", int'(carry_inh), 0);
        chk("lit_async_blink", int'(blink_mask), 0);
        chk("lit_async_running", int'(running), 1);
        cyc(0, 0, 0, 1, 0);
        rst_n = 1;
        s0 = n_clr;
        cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("lit_no_clr_after_reset", n_clr - s0, 0);
        chk("lit_after_reset_mode", int'(mode), 0);
        for (int blk = 0; blk < 16; blk++) begin
            automatic bit quiet = $urandom_range(0, 2) == 0;
            for (int c = 0; c < 250; c++) begin
                @(negedge clk); #1;
                t1  = $urandom_range(0, 5) == 0;
                tbk = $urandom_range(0, 3) == 0;
                if (!quiet) begin
                    if ($urandom_range(0, 4) == 0) mb = !mb;
                    if ($urandom_range(0, 4) == 0) ib = !ib;
                    if ($urandom_range(0, 4) == 0) rb = !rb;
                end
                rst_n = $urandom_range(0, 599) != 0;
            end
        end
        @(negedge clk); #1;
        rst_n = 1; t1 = 0; tbk = 0; mb = 0; ib = 0; rb = 0;
        repeat (3) cyc(0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
